// File: rtl/reg_writeback_ctrl_pkg.sv
// Shared definitions for the register-file writeback path.
// Holds the register file geometry, the writeback source encoding, the
// packed FIFO/port entry layout and a one-hot helper for the scoreboard.
package reg_writeback_ctrl_pkg;

  localparam int unsigned REG_ADDR_W = 3;
  localparam int unsigned REG_DATA_W = 8;
  localparam int unsigned NUM_REGS   = 8;

  // Writeback source; stored with every queued entry so the scoreboard
  // knows whether a write retires an outstanding load.
  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_MEM = 1'b1
  } wb_src_e;

  // One pending register-file write: {src, dest, data}.
  typedef struct packed {
    wb_src_e                 src;
    logic [REG_ADDR_W-1:0]   dest;
    logic [REG_DATA_W-1:0]   data;
  } wb_entry_t;

  // One-hot register mask for scoreboard set/clear.
  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] r);
    return NUM_REGS'(1) << r;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// In-order pending-write queue: up to two pushes and one pop per edge.
// Ports:
//   CLK, RESET_N      clock, async active-low reset
//   wr0_en/wr0_entry  first push (older request)
//   wr1_en/wr1_entry  second push (younger); only asserted with wr0_en
//   rd_en             pop the head this edge
//   rd_entry_c        current head (combinational view of storage)
//   count, full, empty registered occupancy
// The caller guarantees pushes never exceed the free slots (pop included).
module wb_fifo
  import reg_writeback_ctrl_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             wr0_en,
  input  wb_entry_t        wr0_entry,
  input  logic             wr1_en,
  input  wb_entry_t        wr1_entry,
  input  logic             rd_en,
  output wb_entry_t        rd_entry_c,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  wb_entry_t          mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr1_ptr_c;
  logic [CNT_W-1:0]   count_nxt_c;

  // Second push lands right behind the first one.
  assign wr1_ptr_c   = wr_ptr + PTR_W'(wr0_en);
  assign count_nxt_c = count + CNT_W'(wr0_en) + CNT_W'(wr1_en) - CNT_W'(rd_en);
  assign rd_entry_c  = mem[rd_ptr];

  // Storage needs no reset; occupancy is tracked by the pointers.
  always_ff @(posedge CLK) begin
    if (wr0_en) mem[wr_ptr]    <= wr0_entry;
    if (wr1_en) mem[wr1_ptr_c] <= wr1_entry;
  end

  // Pointers and occupancy flags.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      wr_ptr <= wr_ptr + PTR_W'(wr0_en) + PTR_W'(wr1_en);
      rd_ptr <= rd_ptr + PTR_W'(rd_en);
      count  <= count_nxt_c;
      full   <= (count_nxt_c == CNT_W'(DEPTH));
      empty  <= (count_nxt_c == '0);
    end
  end

endmodule

// File: rtl/reg_writeback_ctrl.sv
// Register-file write-port initiator. Merges ALU results and load returns
// onto the single write port, queues collisions in order, tracks
// outstanding loads per register and flags dropped requests.
// Ports:
//   CLK, RESET_N                       clock, async active-low reset
//   ALU_VALID/ALU_DATA/ALU_DEST        ALU writeback request
//   MEM_VALID/MEM_DATA/MEM_DEST        load-return writeback request
//   LOAD_ISSUE/LOAD_DEST               load issued by the decoder
//   WRITE/IN/INADDRESS                 register file write port
//   BUSY_MASK                          outstanding-load scoreboard
//   STALL                              queue nearly full (from registered count)
//   OVERFLOW                           sticky, a request was dropped
// Build option: define WB_BYPASS_EN to drive the port combinationally from
// the incoming request whenever the queue and port register are idle.
module reg_writeback_ctrl
  import reg_writeback_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic                  ALU_VALID,
  input  logic [REG_DATA_W-1:0] ALU_DATA,
  input  logic [REG_ADDR_W-1:0] ALU_DEST,
  input  logic                  MEM_VALID,
  input  logic [REG_DATA_W-1:0] MEM_DATA,
  input  logic [REG_ADDR_W-1:0] MEM_DEST,
  input  logic                  LOAD_ISSUE,
  input  logic [REG_ADDR_W-1:0] LOAD_DEST,
  output logic                  WRITE,
  output logic [REG_DATA_W-1:0] IN,
  output logic [REG_ADDR_W-1:0] INADDRESS,
  output logic [NUM_REGS-1:0]   BUSY_MASK,
  output logic                  STALL,
  output logic                  OVERFLOW
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  wb_entry_t             mem_req_c;
  wb_entry_t             alu_req_c;
  wb_entry_t             head_c;

  logic [CNT_W-1:0]      fifo_count;
  logic                  fifo_full;
  logic                  fifo_empty;

  logic                  port_load_c;
  wb_entry_t             port_entry_c;
  logic                  pop_c;
  logic                  cand0_v_c;
  wb_entry_t             cand0_c;
  logic                  cand1_v_c;
  wb_entry_t             cand1_c;
  logic [CNT_W-1:0]      free_slots_c;
  logic                  wr0_c;
  logic                  wr1_c;
  logic                  drop_c;
  logic                  bypass_now_c;
  logic [NUM_REGS-1:0]   set_mask_c;
  logic [NUM_REGS-1:0]   clr_mask_c;

  logic                  write_q;
  logic [REG_DATA_W-1:0] in_q;
  logic [REG_ADDR_W-1:0] addr_q;
  logic [NUM_REGS-1:0]   busy_q;
  logic                  ovf_q;

  assign mem_req_c = '{src: SRC_MEM, dest: MEM_DEST, data: MEM_DATA};
  assign alu_req_c = '{src: SRC_ALU, dest: ALU_DEST, data: ALU_DATA};

  wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .CLK        (CLK),
    .RESET_N    (RESET_N),
    .wr0_en     (wr0_c),
    .wr0_entry  (cand0_c),
    .wr1_en     (wr1_c),
    .wr1_entry  (cand1_c),
    .rd_en      (pop_c),
    .rd_entry_c (head_c),
    .count      (fifo_count),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  // Port selection: queue head first, else MEM, else ALU. Requests not
  // taken into the port become enqueue candidates, MEM before ALU.
  always_comb begin
    port_load_c  = 1'b0;
    port_entry_c = head_c;
    pop_c        = 1'b0;
    cand0_v_c    = 1'b0;
    cand0_c      = mem_req_c;
    cand1_v_c    = 1'b0;
    cand1_c      = alu_req_c;

    if (!fifo_empty) begin
      port_load_c  = 1'b1;
      pop_c        = 1'b1;
      if (MEM_VALID) begin
        cand0_v_c = 1'b1;
        cand0_c   = mem_req_c;
        cand1_v_c = ALU_VALID;
        cand1_c   = alu_req_c;
      end else begin
        cand0_v_c = ALU_VALID;
        cand0_c   = alu_req_c;
      end
    end else if (MEM_VALID) begin
      port_load_c  = 1'b1;
      port_entry_c = mem_req_c;
      cand0_v_c    = ALU_VALID;
      cand0_c      = alu_req_c;
    end else if (ALU_VALID) begin
      port_load_c  = 1'b1;
      port_entry_c = alu_req_c;
    end
  end

  // Slots available this edge; the slot freed by a same-edge pop is reusable.
  assign free_slots_c = CNT_W'(DEPTH) - fifo_count + CNT_W'(pop_c);
  assign wr0_c        = cand0_v_c && (!fifo_full || pop_c);
  assign wr1_c        = cand1_v_c && (free_slots_c >= CNT_W'(2));
  assign drop_c       = (cand0_v_c && !wr0_c) || (cand1_v_c && !wr1_c);

`ifdef WB_BYPASS_EN
  // Incoming request goes straight to the port when nothing is queued or
  // being presented; the port register then idles for that write.
  assign bypass_now_c = fifo_empty && !write_q && port_load_c;
  assign WRITE        = bypass_now_c | write_q;
  assign IN           = bypass_now_c ? port_entry_c.data : in_q;
  assign INADDRESS    = bypass_now_c ? port_entry_c.dest : addr_q;
`else
  assign bypass_now_c = 1'b0;
  assign WRITE        = write_q;
  assign IN           = in_q;
  assign INADDRESS    = addr_q;
`endif

  // Scoreboard: a load write clears its bit when it reaches the port;
  // a same-edge issue to that register wins.
  assign set_mask_c = LOAD_ISSUE ? reg_onehot(LOAD_DEST) : '0;
  assign clr_mask_c = (port_load_c && (port_entry_c.src == SRC_MEM))
                      ? reg_onehot(port_entry_c.dest) : '0;

  // Port register, scoreboard and sticky overflow.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      write_q <= 1'b0;
      in_q    <= '0;
      addr_q  <= '0;
      busy_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      write_q <= port_load_c && !bypass_now_c;
      if (port_load_c) begin
        in_q   <= port_entry_c.data;
        addr_q <= port_entry_c.dest;
      end
      busy_q <= (busy_q & ~clr_mask_c) | set_mask_c;
      ovf_q  <= ovf_q | drop_c;
    end
  end

  assign BUSY_MASK = busy_q;
  assign OVERFLOW  = ovf_q;
  assign STALL     = (fifo_count >= CNT_W'(DEPTH - 1));

endmodule
